// File: rtl/lfsr_seg_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : lfsr_seg_gen                                                    |
// | Function : WIDTH-bit Fibonacci LFSR with masked feedback, stepped by a     |
// |            synchronised button edge (manual) or a prescaler (auto), with   |
// |            hex seven-segment encoding of every nibble of the value shown.  |
// |            Optional history display enabled by macro LFSR_HIST_EN.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module lfsr_seg_gen #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = 8'h1D,
  parameter int               PRESCALE   = 1000,
  parameter int               HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              i_seed,
  input  logic                          i_load,
  input  logic                          i_step,
  input  logic                          i_mode,
`ifdef LFSR_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_sel,
`endif
  output logic [WIDTH-1:0]              o_rand,
  output logic [WIDTH*2-1:0]            o_seg,
  output logic                          o_step_flag
);

  localparam int c_cnt_w  = $clog2(PRESCALE);
  localparam int c_digits = WIDTH / 4;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PRESCALE - 1);

  // Hex digit to active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  logic [2:0]         r_load_sync;
  logic [2:0]         r_step_sync;
  logic [WIDTH-1:0]   r_lfsr;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_flag;

  logic               w_load_edge;
  logic               w_step_edge;
  logic               w_step;
  logic               w_tick;
  logic               w_fb;
  logic [WIDTH-1:0]   w_lfsr_nxt;
  logic [WIDTH-1:0]   w_disp;

  // Two synchroniser flops plus one edge-detect flop per button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_sync <= 3'b000;
      r_step_sync <= 3'b000;
    end else begin
      r_load_sync <= {r_load_sync[1:0], i_load};
      r_step_sync <= {r_step_sync[1:0], i_step};
    end
  end

  assign w_load_edge = r_load_sync[1] & ~r_load_sync[2];
  assign w_step_edge = r_step_sync[1] & ~r_step_sync[2];

  // Update source selection: load beats any step; manual edges only count in manual mode.
  always_comb begin
    w_tick = i_mode & (r_cnt == c_cnt_last);
    w_step = (~i_mode & w_step_edge) | w_tick;
    w_fb   = ^(r_lfsr & TAPS);
    w_lfsr_nxt = r_lfsr;
    if (w_load_edge) begin
      // An all-zero seed would lock the LFSR, so substitute 1.
      w_lfsr_nxt = (i_seed == '0) ? WIDTH'(1) : i_seed;
    end else if (w_step) begin
      w_lfsr_nxt = {w_fb, r_lfsr[WIDTH-1:1]};
    end
  end

  // LFSR register and one-cycle update flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= WIDTH'(1);
      r_flag <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_flag <= w_load_edge | w_step;
    end
  end

  // Prescaler: held at 0 in manual mode so the first auto step is PRESCALE cycles in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_mode || w_load_edge || (r_cnt == c_cnt_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef LFSR_HIST_EN
  localparam int c_hist_w = $clog2(HIST_DEPTH);

  logic [WIDTH-1:0]    r_hist [HIST_DEPTH];
  logic [c_hist_w-1:0] r_wr_ptr;
  logic [c_hist_w-1:0] w_rd_idx;

  // Circular history: the value being replaced is stored on each update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
      r_wr_ptr <= '0;
    end else if (w_load_edge || w_step) begin
      r_hist[r_wr_ptr] <= r_lfsr;
      r_wr_ptr         <= r_wr_ptr + 1'b1;
    end
  end

  // Entry written n updates ago sits n slots behind the write pointer.
  assign w_rd_idx = r_wr_ptr - i_hist_sel;
  assign w_disp   = (i_hist_sel == '0) ? r_lfsr : r_hist[w_rd_idx];
`else
  assign w_disp = r_lfsr;
`endif

  for (genvar d = 0; d < c_digits; d++) begin : g_seg
    assign o_seg[8*d +: 8] = seg7(w_disp[4*d +: 4]);
  end

  assign o_rand      = r_lfsr;
  assign o_step_flag = r_flag;

endmodule

`default_nettype wire
